run_length_detector: RTL
========================

# run_length_detector

Parametrised successor to the fixed five-ones bounded-run detector. It detects a run of ones bounded by zeros on a serial bit stream. The run length is programmable at runtime, with an exact or at-least match mode. Unlike the fixed version, detection continues while earlier hits are waiting to be acknowledged: hits queue in a pending counter that is drained by `ack`, and a lifetime hit counter is kept. The block sits between the serial input front end and the control FSM that consumes `w`.

## Interface
- `MAX_RUN`, 15: largest programmable run length. `RW = $clog2(MAX_RUN+1)`.
- `PEND_W`, 4: width of the pending-hit counter.
- `CNT_W`, 8: width of the lifetime hit counter.
- `clk`  in  1  clock; the only clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  the stream bit `i` is sampled only when this is 1.
- `i`  in  1  serial stream bit.
- `len`  in  RW  target run length. 0 or >MAX_RUN never matches.
- `mode`  in  1  0 = exact (run == len), 1 = at-least (run >= len).
- `ack`  in  1  consumer acknowledges one pending hit.
- `w`  out  1  high while pending != 0.
- `pending`  out  PEND_W  number of unacknowledged hits.
- `hit_cnt`  out  CNT_W  total hits since reset, saturating.
- `ovf`  out  1  sticky flag: a hit was lost because `pending` was full.

## Operation
- State machine has three states.
  - WAIT_Z: waiting for a leading zero. This is the reset state.
  - ZERO: a leading zero has been seen; run = 0.
  - RUN: counting ones in `run` (RW bits).
- All transitions occur only on cycles with `i_valid`=1. With `i_valid`=0, state, `run` and the hit logic hold.
- WAIT_Z: `i`=0 → ZERO; `i`=1 → stay.
- ZERO: `i`=1 → RUN with run=1; `i`=0 → stay.
- RUN, `i`=1:
  - Exact mode, run+1 > len → WAIT_Z, run cleared (run too long).
  - Otherwise run increments, saturating at MAX_RUN, and the state stays RUN.
- RUN, `i`=0:
  - A hit occurs if the match condition holds with the current `run` and `len`.
  - The next state is ZERO in all cases.
  - The terminating zero doubles as the leading zero of the next pattern, so patterns may overlap on that shared zero.
- Hit accounting:
  - On a hit, `pending` increments and `hit_cnt` increments, each saturating at all-ones.
  - A hit with `pending` full sets `ovf`. `ovf` clears only on reset.
- Acknowledge:
  - `ack` with pending>0 decrements `pending`.
  - `ack` with pending=0 is ignored.
  - Hit and `ack` in the same cycle leave `pending` unchanged, and `ovf` is not set.
- `len` and `mode` are not latched. They are evaluated on every valid sample, so a change takes effect on the next sample against the current `run`.

## Timing
- Reset values: state=WAIT_Z, run=0, `w`=0, `pending`=0, `hit_cnt`=0, `ovf`=0.
- All outputs are registered or decoded directly from registers; there are no combinational paths from inputs to outputs.
- Hit latency: the sampling edge of the terminating zero updates `pending`, so `w` is high in the following cycle.
- `ack` takes effect on the edge where it is sampled. For a single pending hit, `w` falls the next cycle.
- Reset asserted mid-run discards the partial run and all pending hits immediately, asynchronously.

## Structure
- Package `run_det_pkg` holds:
  - the state type with encodings WAIT_Z=2'd0, ZERO=2'd1, RUN=2'd2; 2'd3 recovers to WAIT_Z;
  - the mode constants MODE_EXACT=1'b0 and MODE_ATLEAST=1'b1.
- Sub-module `run_det_pending` implements the saturating up/down pending counter plus `ovf`. The top level contains the FSM, the run counter and `hit_cnt`.

## Test plan
All scenarios use MAX_RUN=15 and `i_valid`=1 unless stated otherwise.
- **Exact match:** len=5, mode=0, stream 0,1,1,1,1,1,0 → `w`=1 the cycle after the last 0; `pending`=1, `hit_cnt`=1.
- **Too long, then overlap:**
  - len=5, mode=0, stream 0, six 1s, 0 → no hit.
  - Then 1,1,1,1,1,0 (no extra leading zero) → exactly one hit.
  - Then 0,1,1,1,1,1,0,1,1,1,1,1,0 → two more hits; `hit_cnt`=3, `pending`=3.
- **At-least and gaps:** len=3, mode=1, stream 0, seven 1s, 0, with `i_valid`=0 gaps of 2 cycles between bits → exactly one hit; gap cycles change nothing.
- **Acknowledge:**
  - pending=2; `ack` and a hit in the same cycle → `pending` stays 2.
  - Two more `ack` cycles → `pending`=0, `w`=0.
  - A further `ack` → no underflow.
- **Saturation:** PEND_W=2, four hits with no `ack` → `pending`=3, `ovf`=1, `hit_cnt`=4.
- **Reset and config corner:**
  - `rst` pulsed after 0,1,1 → every output is 0; a following 1,1,1,0 gives no hit because no leading zero has been seen.
  - len=0: no hits for any stream.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types for the programmable bounded-run detector.
// State encoding and match-mode constants.
package run_det_pkg;

    typedef enum logic [1:0] {
        WAIT_Z = 2'd0,
        ZERO   = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic MODE_EXACT   = 1'b0;
    localparam logic MODE_ATLEAST = 1'b1;

endpackage

// File: rtl/run_det_pending.sv
// Saturating up/down counter of unacknowledged hits.
// Also holds the sticky overflow flag for hits lost while full.
module run_det_pending #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hit,
    input  logic         ack,
    output logic [W-1:0] pending,
    output logic         ovf
);

    logic full;
    logic empty;

    assign full  = &pending;
    assign empty = (pending == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else if (hit && !ack) begin
            if (full) ovf <= 1'b1;
            else      pending <= pending + 1'b1;
        end else if (ack && !hit && !empty) begin
            pending <= pending - 1'b1;
        end
    end

endmodule

// File: rtl/run_length_detector.sv
// Detects a zero-bounded run of ones of programmable length,
// queuing hits in a pending counter drained by ack.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int MAX_RUN = 15,
    parameter int PEND_W  = 4,
    parameter int CNT_W   = 8,
    parameter int RW      = $clog2(MAX_RUN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i,
    input  logic [RW-1:0]     len,
    input  logic              mode,
    input  logic              ack,
    output logic              w,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              ovf
);

    localparam logic [RW-1:0] RMAX = RW'(MAX_RUN);

    state_t        state, state_n;
    logic [RW-1:0] run, run_n;
    logic [RW:0]   run_inc;
    logic          len_ok;
    logic          match;
    logic          hit;

    assign run_inc = {1'b0, run} + 1'b1;
    assign len_ok  = (len != '0) && (len <= RMAX);
    assign match   = len_ok && ((mode == MODE_ATLEAST) ? (run >= len)
                                                       : (run == len));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_Z;
            run   <= '0;
        end else begin
            state <= state_n;
            run   <= run_n;
        end
    end

    always_comb begin
        state_n = state;
        run_n   = run;
        hit     = 1'b0;
        if (i_valid) begin
            case (state)
                WAIT_Z: begin
                    if (!i) state_n = ZERO;
                end
                ZERO: begin
                    if (i) begin
                        state_n = RUN;
                        run_n   = RW'(1);
                    end
                end
                RUN: begin
                    if (i) begin
                        if (mode == MODE_EXACT && run_inc > {1'b0, len}) begin
                            state_n = WAIT_Z;
                            run_n   = '0;
                        end else if (run != RMAX) begin
                            run_n = run + 1'b1;
                        end
                    end else begin
                        // closing zero is also the next leading zero
                        hit     = match;
                        state_n = ZERO;
                        run_n   = '0;
                    end
                end
                default: begin
                    state_n = WAIT_Z;
                    run_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      hit_cnt <= '0;
        else if (hit && !(&hit_cnt))  hit_cnt <= hit_cnt + 1'b1;
    end

    run_det_pending #(
        .W(PEND_W)
    ) u_pend (
        .clk    (clk),
        .rst    (rst),
        .hit    (hit),
        .ack    (ack),
        .pending(pending),
        .ovf    (ovf)
    );

    assign w = (pending != '0);

endmodule
